// File: rtl/keypad_pkg.sv
// Shared state encoding and key-code constants for the keypad lock.
package keypad_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENTRY,
    ST_CHECK,
    ST_OPEN,
    ST_LOCKOUT,
    ST_PROGRAM
  } state_t;

  localparam logic [3:0] KEY_PROG  = 4'hA;
  localparam logic [3:0] KEY_CLEAR = 4'hE;
  localparam logic [3:0] KEY_ENTER = 4'hF;

  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'd9;
  endfunction

endpackage

// File: rtl/key_edge.sv
// Turns the debounced key-held level into a one-cycle keystroke strobe with its key code.
module key_edge (
  input  logic       CLOCK_50,
  input  logic       Reset,
  input  logic [3:0] key_in,
  input  logic       key_valid,
  output logic       key_stb,
  output logic [3:0] key_code
);

  logic valid_q;
  logic armed;

  // armed stays low for the first cycle after reset so a key held through release is not a press
  always_ff @(posedge CLOCK_50) begin
    if (!Reset) begin
      valid_q <= 1'b0;
      armed   <= 1'b0;
    end else begin
      valid_q <= key_valid;
      armed   <= 1'b1;
    end
  end

  assign key_stb  = armed & key_valid & ~valid_q;
  assign key_code = key_in;

endmodule

// File: rtl/keypad_lock.sv
// Keypad combination lock: code entry, check, timed open, fail lockout and code programming.
module keypad_lock
  import keypad_pkg::*;
#(
  parameter int                    CODE_LEN       = 4,
  parameter int                    MAX_FAILS      = 3,
  parameter int                    UNLOCK_CYCLES  = 250_000_000,
  parameter int                    LOCKOUT_CYCLES = 500_000_000,
  parameter logic [4*CODE_LEN-1:0] RESET_CODE     = 16'h1234
) (
  input  logic                  CLOCK_50,
  input  logic                  Reset,
  input  logic [3:0]            key_in,
  input  logic                  key_valid,
  output logic [4*CODE_LEN-1:0] disp_digits,
  output logic [CODE_LEN-1:0]   disp_blank,
  output logic                  unlocked,
  output logic                  locked_out,
  output logic                  prog_mode,
  output logic [1:0]            fail_count
);

  localparam int                BUF_W       = 4 * CODE_LEN;
  localparam int                CNT_W       = $clog2(CODE_LEN + 1);
  localparam logic [CNT_W-1:0]  CNT_FULL    = CNT_W'(CODE_LEN);
  localparam logic [31:0]       UNLOCK_LOAD = 32'(UNLOCK_CYCLES - 1);
  localparam logic [31:0]       LOCK_LOAD   = 32'(LOCKOUT_CYCLES - 1);

  logic            key_stb;
  logic [3:0]      key_code;

  state_t          state, state_d;
  logic [BUF_W-1:0] buffer, buffer_d;
  logic [BUF_W-1:0] code, code_d;
  logic [CNT_W-1:0] count, count_d;
  logic [1:0]      fail_d;
  logic [31:0]     timer, timer_d;
  logic            expired;

  key_edge u_key_edge (
    .CLOCK_50  (CLOCK_50),
    .Reset     (Reset),
    .key_in    (key_in),
    .key_valid (key_valid),
    .key_stb   (key_stb),
    .key_code  (key_code)
  );

  always_ff @(posedge CLOCK_50) begin
    if (!Reset) begin
      state      <= ST_IDLE;
      buffer     <= '0;
      code       <= RESET_CODE;
      count      <= '0;
      fail_count <= 2'd0;
      timer      <= 32'd0;
    end else begin
      state      <= state_d;
      buffer     <= buffer_d;
      code       <= code_d;
      count      <= count_d;
      fail_count <= fail_d;
      timer      <= timer_d;
    end
  end

  assign expired = (timer == 32'd0);

  always_comb begin
    state_d  = state;
    buffer_d = buffer;
    code_d   = code;
    count_d  = count;
    fail_d   = fail_count;
    timer_d  = expired ? 32'd0 : timer - 32'd1;
    case (state)
      ST_IDLE: begin
        if (key_stb && is_digit(key_code)) begin
          buffer_d = BUF_W'(key_code);
          count_d  = CNT_W'(1);
          state_d  = ST_ENTRY;
        end
      end
      ST_ENTRY, ST_PROGRAM: begin
        if (key_stb) begin
          if (is_digit(key_code)) begin
            if (count != CNT_FULL) begin
              buffer_d = {buffer[BUF_W-5:0], key_code};
              count_d  = count + CNT_W'(1);
            end
          end else if (key_code == KEY_CLEAR) begin
            buffer_d = '0;
            count_d  = '0;
            state_d  = (state == ST_PROGRAM) ? ST_PROGRAM : ST_IDLE;
          end else if (key_code == KEY_ENTER) begin
            if (state == ST_ENTRY) begin
              if (count == CNT_FULL) begin
                state_d = ST_CHECK;
              end else begin
                buffer_d = '0;
                count_d  = '0;
                state_d  = ST_IDLE;
              end
            end else if (count == CNT_FULL) begin
              code_d   = buffer;
              buffer_d = '0;
              count_d  = '0;
              state_d  = ST_IDLE;
            end
          end
        end
      end
      ST_CHECK: begin
        buffer_d = '0;
        count_d  = '0;
        if (buffer == code) begin
          fail_d  = 2'd0;
          timer_d = UNLOCK_LOAD;
          state_d = ST_OPEN;
        end else if ((32'(fail_count) + 32'd1) == 32'(MAX_FAILS)) begin
          fail_d  = 2'd0;
          timer_d = LOCK_LOAD;
          state_d = ST_LOCKOUT;
        end else begin
          fail_d  = fail_count + 2'd1;
          state_d = ST_IDLE;
        end
      end
      ST_OPEN: begin
        // expiry wins over any keystroke landing on the same cycle
        if (expired) begin
          state_d = ST_IDLE;
        end else if (key_stb && key_code == KEY_ENTER) begin
          state_d = ST_IDLE;
        end else if (key_stb && key_code == KEY_PROG) begin
          buffer_d = '0;
          count_d  = '0;
          state_d  = ST_PROGRAM;
        end
      end
      ST_LOCKOUT: begin
        if (expired) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign disp_digits = buffer;
  assign unlocked    = (state == ST_OPEN);
  assign locked_out  = (state == ST_LOCKOUT);
  assign prog_mode   = (state == ST_PROGRAM);

  always_comb begin
    disp_blank = '1;
    if (state != ST_OPEN && state != ST_LOCKOUT) begin
      for (int i = 0; i < CODE_LEN; i++) disp_blank[i] = (CNT_W'(i) >= count);
    end
  end

endmodule

// File: doc/keypad_lock.md
KEYPAD_LOCK -- requirements
Module: keypad_lock

Interface
REQ-001 Parameter CODE_LEN, default 4, number of hex digits in the code (fixed 4 for this revision).
REQ-002 Parameter MAX_FAILS, default 3, wrong entries before lockout.
REQ-003 Parameter UNLOCK_CYCLES, default 250_000_000, which is 5 s open time at 50 MHz.
REQ-004 Parameter LOCKOUT_CYCLES, default 500_000_000, which is 10 s lockout at 50 MHz.
REQ-005 Parameter RESET_CODE, default 16'h1234, code loaded at reset.
REQ-006 CLOCK_50  input  1  system clock; all logic SHALL be on its rising edge.
REQ-007 Reset  input  1  synchronous, active-low reset.
REQ-008 key_in  input  4  debounced key code: 0-9 digits; A=program; B/C/D ignored; E(*)=clear; F(#)=enter.
REQ-009 key_valid  input  1  debounced key-held level.
REQ-010 disp_digits  output  16  four entry nibbles; [3:0] is the newest digit.
REQ-011 disp_blank  output  4  per-digit blank enable, 1=blank, feeding the SevenSegment blankZero inputs.
REQ-012 unlocked  output  1  high in OPEN.
REQ-013 locked_out  output  1  high in LOCKOUT.
REQ-014 prog_mode  output  1  high in PROGRAM.
REQ-015 fail_count  output  2  consecutive wrong entries.

Function
REQ-016 Keystroke = key_valid high while last-cycle key_valid low; key_in SHALL be sampled on that cycle only, with exactly one event per press.
REQ-017 States: IDLE, ENTRY, CHECK, OPEN, LOCKOUT, PROGRAM.
REQ-018 IDLE: a digit keystroke loads it into buffer[3:0], sets count=1 and goes to ENTRY; other keys are ignored.
REQ-019 ENTRY/PROGRAM digit: if count<4, shift buffer left 4 bits, insert digit, count+1; at count=4, ignore the digit.
REQ-020 E in ENTRY: clear buffer and count and go to IDLE; E in PROGRAM: clear buffer and count and stay in PROGRAM.
REQ-021 F in ENTRY with count=4: go to CHECK; F with count<4: clear buffer, go to IDLE, no fail.
REQ-022 CHECK lasts exactly one cycle; keystrokes on that cycle are dropped.
REQ-023 CHECK match: go to OPEN, fail_count=0, buffer cleared; unlocked SHALL assert 2 cycles after the F keystroke cycle.
REQ-024 CHECK mismatch: fail_count+1; if the new value equals MAX_FAILS, go to LOCKOUT and set fail_count=0; else go to IDLE; buffer cleared in both cases.
REQ-025 OPEN: timer runs UNLOCK_CYCLES, then goes to IDLE.
REQ-026 F in OPEN goes to IDLE immediately; A in OPEN goes to PROGRAM with buffer cleared; other keys are ignored.
REQ-027 PROGRAM: F with count=4 writes buffer to the code register and goes to IDLE; F with count<4 is ignored.
REQ-028 PROGRAM SHALL have no timeout.
REQ-029 LOCKOUT: all keystrokes are ignored; the timer runs LOCKOUT_CYCLES, then goes to IDLE.
REQ-030 A keystroke arriving on a timer-expiry cycle SHALL be dropped, and the expiry transition wins.
REQ-031 disp_digits = buffer.
REQ-032 disp_blank[i] = 1 when i >= count; all four bits SHALL be 1 in OPEN and in LOCKOUT.
REQ-033 Timer width: 32 bits; it SHALL load on state entry and count down to 0.

Reset
REQ-034 Reset low SHALL take priority over everything and apply in any state, including mid-entry and mid-timer.
REQ-035 Reset values: state IDLE, buffer 0, count 0, code RESET_CODE, fail_count 0, timer 0, edge register 0.
REQ-036 Reset output values: disp_digits 0, disp_blank 4'b1111, unlocked 0, locked_out 0, prog_mode 0.
REQ-037 A key held through reset release SHALL NOT generate a keystroke.

Structure
REQ-038 State encoding and key-code constants (KEY_PROG=A, KEY_CLEAR=E, KEY_ENTER=F) SHALL live in shared package keypad_pkg.
REQ-039 One sub-module, key_edge, SHALL do edge detection and key sampling; the FSM, buffer and timer SHALL stay in keypad_lock.
REQ-040 The block is driven by Debounce outputs and feeds SevenSegment; the top level SHALL contain no lock logic.

Verification (UNLOCK_CYCLES=20, LOCKOUT_CYCLES=40)
REQ-041 Keys 1,2,3,4,F after reset: unlocked=1 2 cycles after F, stays high 20 cycles, then 0.
REQ-042 Three entries of 9,9,9,9,F: fail_count 1 then 2; locked_out=1 after the third; key 1 pressed during lockout is ignored; IDLE after 40 cycles.
REQ-043 Keys 1,2,E,5: disp_digits=16'h0005, disp_blank=4'b1110.
REQ-044 Program path: 1234F, A, 5678F, then 1234F: entry fails with fail_count=1; then 5678F: unlocked=1.
REQ-045 Keys 1,2,3,4,7: 7 is ignored, disp_digits=16'h1234; then 1,2,F with count<4: IDLE, fail_count unchanged.
REQ-046 Reset pulsed mid-entry (after 1,2) and mid-lockout: all outputs at reset values on the next cycle; code reverts to 16'h1234.
